// File: rtl/regfile64_wb_sched_pkg.sv
// Shared widths and writeback source encodings for the regfile64 write path.
package regfile_pkg;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREGS  = 32;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;
endpackage

// File: rtl/regfile64_wb_sched_if.sv
// Writeback request bundle for both sources (A = ALU, B = load) toward the scheduler.
interface regfile64_wb_sched_if #(
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W
) ();
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/regfile64_wb_sched_arb.sv
// Two-way round-robin arbiter; grants are suppressed while reset is held.
module rr_arb2
  import regfile_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  src_e last_q, last_d;

  always_comb begin
    grant = '0;
    if (!rst) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_q == SRC_A) ? 2'b10 : 2'b01;
        default: grant = '0;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant[SRC_B])      last_d = SRC_B;
    else if (grant[SRC_A]) last_d = SRC_A;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= src_e'(~PRIO_INIT);
    else     last_q <= last_d;
  end
endmodule

// File: rtl/regfile64_wb_sched.sv
// Shares the regfile64 write port between ALU and load writebacks and tracks pending destinations.
module regfile64_wb_sched
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W    = regfile_pkg::ADDR_W,
  parameter int unsigned NREGS     = regfile_pkg::NREGS,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic                Clk,
  input  logic                Reset,
  regfile64_wb_sched_if.slave wb,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                issue_stall,
  input  logic [ADDR_W-1:0]   chk_r_addr,
  input  logic [ADDR_W-1:0]   chk_s_addr,
  output logic                r_busy,
  output logic                s_busy,
  output logic                W_en,
  output logic [ADDR_W-1:0]   W_Addr,
  output logic [DATA_W-1:0]   WR,
  output logic                err_spurious
);
  logic [1:0]        req, grant;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              err_q, err_d;
  logic              set_hit;

  assign req[SRC_A] = wb.a_valid;
  assign req[SRC_B] = wb.b_valid;

  rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
    .clk   (Clk),
    .rst   (Reset),
    .req   (req),
    .grant (grant)
  );

  assign wb.a_ready = grant[SRC_A];
  assign wb.b_ready = grant[SRC_B];

  always_comb begin
    wen_d   = |grant;
    waddr_d = waddr_q;
    wr_d    = wr_q;
    if (grant[SRC_B]) begin
      waddr_d = wb.b_addr;
      wr_d    = wb.b_data;
    end else if (grant[SRC_A]) begin
      waddr_d = wb.a_addr;
      wr_d    = wb.a_data;
    end
  end

  assign issue_stall = busy_q[issue_addr];
  assign r_busy      = busy_q[chk_r_addr];
  assign s_busy      = busy_q[chk_s_addr];
  assign set_hit     = issue_valid && !issue_stall;

  // Clear before set so a same-address claim re-owns the register; that collision is not spurious.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
      if (!busy_q[waddr_q] && !(set_hit && (issue_addr == waddr_q)))
        err_d = 1'b1;
    end
    if (set_hit) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wr_q    <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign W_en         = wen_q;
  assign W_Addr       = waddr_q;
  assign WR           = wr_q;
  assign err_spurious = err_q;
endmodule

// File: tb/tb_regfile64_wb_sched.sv
// Directed bench for regfile64_wb_sched with a writeback scoreboard.
module tb_regfile64_wb_sched;
  import regfile_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_stall;
  logic [4:0]  chk_r_addr, chk_s_addr;
  logic        r_busy, s_busy;
  logic        W_en;
  logic [4:0]  W_Addr;
  logic [63:0] WR;
  logic        err_spurious;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;
  wb_t exp_q[$];

  regfile64_wb_sched_if wb ();

  regfile64_wb_sched #(.PRIO_INIT(1'b0)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .wb           (wb),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_stall  (issue_stall),
    .chk_r_addr   (chk_r_addr),
    .chk_s_addr   (chk_s_addr),
    .r_busy       (r_busy),
    .s_busy       (s_busy),
    .W_en         (W_en),
    .W_Addr       (W_Addr),
    .WR           (WR),
    .err_spurious (err_spurious)
  );

  always #5 Clk = ~Clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [63:0] d);
    wb_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Every committed write must match the oldest expected grant
  always @(negedge Clk) begin
    if (Reset === 1'b0 && W_en === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL wb_unexpected observed=W_Addr %0h expected=no write", W_Addr);
      end
      if (exp_q.size() != 0) begin
        wb_t e;
        e = exp_q.pop_front();
        chk64("wb_addr", 64'(W_Addr), 64'(e.addr));
        chk64("wb_data", WR, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    issue_valid = 1'b0; issue_addr = '0;
    chk_r_addr = '0; chk_s_addr = '0;
    wb.a_valid = 1'b1; wb.a_addr = '0; wb.a_data = '0;
    wb.b_valid = 1'b0; wb.b_addr = '0; wb.b_data = '0;

    // reset held with A requesting
    step(); #3;
    chk1("rst_a_ready", wb.a_ready, 1'b0);
    chk1("rst_wen", W_en, 1'b0);
    step(); #3;
    chk1("rst_a_ready2", wb.a_ready, 1'b0);
    chk64("rst_busy", 64'(dut.busy_q), 64'd0);
    chk1("rst_err", err_spurious, 1'b0);
    step();
    Reset = 1'b0; wb.a_valid = 1'b0;

    // contention: A first after reset, then round-robin
    issue_valid = 1'b1; issue_addr = 5'd1;
    #3 chk1("issue1_stall", issue_stall, 1'b0);
    step(); issue_addr = 5'd2;
    step(); issue_addr = 5'd6;
    step(); issue_valid = 1'b0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd1; wb.a_data = 64'h1111_0000_0000_0001;
    wb.b_valid = 1'b1; wb.b_addr = 5'd2; wb.b_data = 64'h2222_0000_0000_0002;
    push(5'd1, 64'h1111_0000_0000_0001);
    #3;
    chk1("cont1_a_ready", wb.a_ready, 1'b1);
    chk1("cont1_b_ready", wb.b_ready, 1'b0);
    chk64("cont_busy", 64'(dut.busy_q), 64'h46);
    step();
    wb.a_addr = 5'd6; wb.a_data = 64'h6666_0000_0000_0006;
    push(5'd2, 64'h2222_0000_0000_0002);
    #3;
    chk1("cont2_a_ready", wb.a_ready, 1'b0);
    chk1("cont2_b_ready", wb.b_ready, 1'b1);
    step();
    wb.b_valid = 1'b0;
    push(5'd6, 64'h6666_0000_0000_0006);
    #3 chk1("cont3_a_ready", wb.a_ready, 1'b1);
    step(); wb.a_valid = 1'b0;
    step(); #3;
    chk1("cont_idle_wen", W_en, 1'b0);
    chk64("cont_busy_clr", 64'(dut.busy_q), 64'd0);
    chk1("cont_err", err_spurious, 1'b0);

    // single write with busy visible through the W_en cycle
    step(); issue_valid = 1'b1; issue_addr = 5'd5;
    step(); issue_valid = 1'b0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd5; wb.a_data = 64'hDEAD_BEEF;
    push(5'd5, 64'hDEAD_BEEF);
    #3 chk1("single_a_ready", wb.a_ready, 1'b1);
    step(); wb.a_valid = 1'b0; chk_r_addr = 5'd5;
    #3;
    chk1("single_wen", W_en, 1'b1);
    chk1("single_busy_wcycle", r_busy, 1'b1);
    step(); #3;
    chk1("single_busy_after", r_busy, 1'b0);
    chk1("single_wen_after", W_en, 1'b0);

    // hazards: stalled issue is ignored
    step(); issue_valid = 1'b1; issue_addr = 5'd7;
    step(); chk_r_addr = 5'd7; chk_s_addr = 5'd8;
    #3;
    chk1("haz_stall", issue_stall, 1'b1);
    chk1("haz_r_busy", r_busy, 1'b1);
    chk1("haz_s_busy", s_busy, 1'b0);
    step(); issue_valid = 1'b0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd7; wb.a_data = 64'h7777_7777;
    push(5'd7, 64'h7777_7777);
    #3 chk64("haz_busy_vec", 64'(dut.busy_q), 64'h80);
    step(); wb.a_valid = 1'b0;
    #3 chk1("haz_stall_wcycle", issue_stall, 1'b1);
    step(); #3 chk1("haz_stall_free", issue_stall, 1'b0);

    // set/clear collision on r9 via a second write to an already-cleared register
    step(); issue_valid = 1'b1; issue_addr = 5'd9;
    step(); issue_valid = 1'b0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd9; wb.a_data = 64'hE1;
    push(5'd9, 64'hE1);
    step(); wb.a_data = 64'hE2;
    push(5'd9, 64'hE2);
    step(); wb.a_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd9; chk_r_addr = 5'd9;
    #3;
    chk1("coll_stall", issue_stall, 1'b0);
    chk1("coll_wen", W_en, 1'b1);
    step(); issue_valid = 1'b0;
    #3;
    chk1("coll_busy9", r_busy, 1'b1);
    chk1("coll_err", err_spurious, 1'b0);
    wb.a_valid = 1'b1; wb.a_data = 64'hE3;
    push(5'd9, 64'hE3);
    step(); wb.a_valid = 1'b0;
    step(); #3 chk64("coll_busy_clr", 64'(dut.busy_q), 64'd0);

    // spurious write is sticky; reset drops the in-flight write and clears the error
    step();
    wb.a_valid = 1'b1; wb.a_addr = 5'd3; wb.a_data = 64'h3333;
    push(5'd3, 64'h3333); chk_r_addr = 5'd3;
    #3 chk1("spur_busy3", r_busy, 1'b0);
    step(); wb.a_valid = 1'b0;
    #3 chk1("spur_err_pre", err_spurious, 1'b0);
    step(); #3 chk1("spur_err_set", err_spurious, 1'b1);
    step();
    wb.a_valid = 1'b1; wb.a_addr = 5'd4; wb.a_data = 64'h4444;
    #3;
    chk1("spur_err_sticky", err_spurious, 1'b1);
    chk1("mid_a_ready", wb.a_ready, 1'b1);
    step(); Reset = 1'b1;
    #3 chk1("mid_rst_a_ready", wb.a_ready, 1'b0);
    step(); #3;
    chk1("mid_rst_wen", W_en, 1'b0);
    chk1("mid_rst_err", err_spurious, 1'b0);
    chk64("mid_rst_busy", 64'(dut.busy_q), 64'd0);
    step(); Reset = 1'b0; wb.a_valid = 1'b0;
    step(); step(); #3;
    chk64("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
